// File: rtl/sum_display.sv
// Display stage: sequential double-dabble conversion of a binary result into
// three active-low seven-segment digits with leading-zero blanking and overflow dashes.
module sum_display #(
    parameter int WIDTH       = 10,
    parameter int BLANK_ZEROS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] value,
    input  logic             load,
    output logic             busy,
    output logic             done,
    output logic [0:6]       HEX0,
    output logic [0:6]       HEX1,
    output logic [0:6]       HEX2
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    localparam logic [3:0] LAST_CNT  = 4'(WIDTH - 1);
    localparam logic [0:6] SEG_BLANK = 7'b1111111;
    localparam logic [0:6] SEG_DASH  = 7'b1111110;

    function automatic logic [0:6] seg_decode(input logic [3:0] digit);
        logic [0:6] seg;
        case (digit)
            4'd0:    seg = 7'b0000001;
            4'd1:    seg = 7'b1001111;
            4'd2:    seg = 7'b0010010;
            4'd3:    seg = 7'b0000110;
            4'd4:    seg = 7'b1001100;
            4'd5:    seg = 7'b0100100;
            4'd6:    seg = 7'b0100000;
            4'd7:    seg = 7'b0001111;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0000100;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    logic [0:0]       state_r;
    logic [WIDTH-1:0] bin_r;
    logic [11:0]      bcd_r;
    logic [3:0]       cnt_r;
    logic             ovf_r;
    logic             done_r;
    logic [0:6]       hex0_r;
    logic [0:6]       hex1_r;
    logic [0:6]       hex2_r;

    logic [11:0]      adj_s;
    logic [11:0]      bcd_nxt_s;
    logic [WIDTH-1:0] bin_nxt_s;
    logic [0:6]       seg0_s;
    logic [0:6]       seg1_s;
    logic [0:6]       seg2_s;

    // Add-3 correction on every BCD nibble, then one left shift of {bcd, bin}.
    always_comb begin
        adj_s = bcd_r;
        for (int n = 0; n < 3; n++) begin
            if (bcd_r[4*n +: 4] >= 4'd5) begin
                adj_s[4*n +: 4] = bcd_r[4*n +: 4] + 4'd3;
            end else begin
                adj_s[4*n +: 4] = bcd_r[4*n +: 4];
            end
        end
        bcd_nxt_s = {adj_s[10:0], bin_r[WIDTH-1]};
        bin_nxt_s = {bin_r[WIDTH-2:0], 1'b0};
    end

    // Segment patterns for the result the final shift produces, with blanking/overflow.
    always_comb begin
        seg0_s = seg_decode(bcd_nxt_s[3:0]);
        seg1_s = seg_decode(bcd_nxt_s[7:4]);
        seg2_s = seg_decode(bcd_nxt_s[11:8]);
        if (ovf_r) begin
            seg0_s = SEG_DASH;
            seg1_s = SEG_DASH;
            seg2_s = SEG_DASH;
        end else if (BLANK_ZEROS != 0) begin
            if (bcd_nxt_s[11:8] == 4'd0) begin
                seg2_s = SEG_BLANK;
                if (bcd_nxt_s[7:4] == 4'd0) begin
                    seg1_s = SEG_BLANK;
                end else begin
                    seg1_s = seg_decode(bcd_nxt_s[7:4]);
                end
            end else begin
                seg2_s = seg_decode(bcd_nxt_s[11:8]);
            end
        end else begin
            seg2_s = seg_decode(bcd_nxt_s[11:8]);
        end
    end

    // Conversion FSM, datapath registers and held display outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            bin_r   <= '0;
            bcd_r   <= 12'd0;
            cnt_r   <= 4'd0;
            ovf_r   <= 1'b0;
            done_r  <= 1'b0;
            hex0_r  <= SEG_BLANK;
            hex1_r  <= SEG_BLANK;
            hex2_r  <= SEG_BLANK;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (load) begin
                        bin_r   <= value;
                        bcd_r   <= 12'd0;
                        cnt_r   <= 4'd0;
                        ovf_r   <= (10'(value) > 10'd999);
                        state_r <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd_r <= bcd_nxt_s;
                    bin_r <= bin_nxt_s;
                    cnt_r <= cnt_r + 4'd1;
                    if (cnt_r == LAST_CNT) begin
                        state_r <= IDLE;
                        done_r  <= 1'b1;
                        hex0_r  <= seg0_s;
                        hex1_r  <= seg1_s;
                        hex2_r  <= seg2_s;
                    end else begin
                        done_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = (state_r == SHIFT);
    assign done = done_r;
    assign HEX0 = hex0_r;
    assign HEX1 = hex1_r;
    assign HEX2 = hex2_r;

endmodule

// File: doc/sum_display.md
# sum_display

Downstream display stage for the summation datapath. It accepts a binary result with a one-cycle load strobe and converts it to three decimal digits using a sequential double-dabble (shift/add-3) engine. It then drives three active-low seven-segment displays with leading-zero blanking and an overflow indication. It replaces any direct binary-to-HEX wiring, and the displays hold the last converted value until the next load.

## Interface
- `WIDTH`, default 10: width of the binary input; legal range 4..10.
- `BLANK_ZEROS`, default 1: 1 blanks leading zero digits; 0 shows all three digits.
- `clk`  in  1  system clock; the block runs entirely in this single clock domain.
- `rst`  in  1  asynchronous, active-low reset.
- `value`  in  WIDTH  binary number to display; sampled only on an accepted load.
- `load`  in  1  one-cycle request; accepted only when `busy`=0.
- `busy`  out  1  high while a conversion is in progress.
- `done`  out  1  one-cycle pulse; HEX outputs updated in the same cycle.
- `HEX0`  out  [0:6]  ones digit, bit 0 = segment a … bit 6 = segment g, active-low.
- `HEX1`  out  [0:6]  tens digit, same encoding.
- `HEX2`  out  [0:6]  hundreds digit, same encoding.

## Operation
- **FSM states:**
  - IDLE: waits for `load`.
  - SHIFT: WIDTH iterations.
- **IDLE + `load`=1 → SHIFT:**
  - Capture `value` into the shift register.
  - Clear the 12-bit BCD accumulator.
  - Iteration counter := 0.
  - Compute overflow flag := (`value` > 999).
- **SHIFT, each cycle:**
  - For each BCD nibble ≥ 5, add 3.
  - Then shift {BCD, binary} left by 1.
  - Counter += 1.
  - When counter reaches WIDTH-1 on this cycle, transition → IDLE.
- **On the final SHIFT edge:**
  - Decode the BCD digits into the HEX registers.
  - Set `done`=1 for the following cycle.
- **Decode table** (a..g order, 0 = lit):
  - 0 = 0000001
  - 1 = 1001111
  - 2 = 0010010
  - 3 = 0000110
  - 4 = 1001100
  - 5 = 0100100
  - 6 = 0100000
  - 7 = 0001111
  - 8 = 0000000
  - 9 = 0000100
  - blank = 1111111
  - dash = 1111110
- **Blanking** (`BLANK_ZEROS`=1):
  - HEX2 is blank if hundreds = 0.
  - HEX1 is blank if hundreds = 0 and tens = 0.
  - HEX0 is never blanked.
- **Overflow:** all three digits show dash; the BCD result is discarded.
- **`load` while `busy`=1:** ignored; the current conversion and `value` capture are unaffected.
- **`value` changing after capture:** no effect.

## Timing
- **Reset (`rst`=0, asynchronous):**
  - State → IDLE.
  - `busy`=0, `done`=0.
  - HEX0..HEX2 = 1111111 (blank).
  - Counter and accumulator cleared.
- **Reset mid-conversion:** aborts immediately; outputs go to their reset values and no `done` is issued.
- **Latency:** `load` sampled at edge k; `busy`=1 from after edge k through edge k+WIDTH; HEX and `done` valid after edge k+WIDTH.
- **Example:** at WIDTH=10, `done` appears exactly 10 cycles after the `load` edge.
- **Throughput:** `done` is asserted in an IDLE cycle, so a `load` in that same cycle is accepted. Back-to-back conversions therefore run every WIDTH+1 cycles.
- **`done`:** exactly one cycle wide; never asserted while `busy`=1.
- **Between conversions:** HEX outputs change only on the `done` edge; they are stable otherwise.
- **Arithmetic limits:** BCD accumulator is 12 bits. Maximum displayable value is 999. With WIDTH ≤ 9 overflow is unreachable.

## Test plan
- **Reset:**
  - Stimulus: assert `rst`=0 asynchronously between clock edges.
  - Required: HEX0..HEX2 = 1111111, `busy`=0, `done`=0 immediately, without waiting for a clock edge.
- **Nominal conversion:**
  - Stimulus: `load` with `value`=496.
  - Required: `busy` high for 10 cycles; `done` pulses for 1 cycle; HEX2=1001100 (4), HEX1=0000100 (9), HEX0=0100000 (6).
- **Leading-zero blanking:**
  - Stimulus: `value`=7 with `BLANK_ZEROS`=1.
  - Required: HEX2=HEX1=1111111, HEX0=0001111.
  - Stimulus: `value`=0.
  - Required: HEX0=0000001 and the other two digits blank.
  - Stimulus: `value`=105.
  - Required: HEX1=0000001 (not blanked).
- **Overflow:**
  - Stimulus: `value`=1000, then `value`=1023.
  - Required: all digits = 1111110 after `done`.
- **Handshake:**
  - Stimulus: `load` again during `busy` with `value`=123.
  - Required: ignored; the first result is displayed.
  - Stimulus: `load` in the `done` cycle with `value`=31.
  - Required: accepted; second `done` 11 cycles after the first; display shows blank, 3, 1.
- **Reset mid-conversion:**
  - Stimulus: assert `rst` at cycle 5 of a conversion of `value`=496.
  - Required: no `done`; displays blank.
  - Stimulus: after release, a new `load` with `value`=250.
  - Required: displays show 2, 5, 0.
